// File: rtl/mem_stage_if.sv
// Bus between the EX stage / debug loader and the MEM stage.
// The pipeline side drives the master modport and mem_stage takes the slave modport.
interface mem_stage_if #(
    parameter int AW = 9
);
    logic          flush;
    logic          rf_le_ex;
    logic [4:0]    ex_rd;
    logic [31:0]   alu_out;
    logic [31:0]   store_data;
    logic          mem_en_ex;
    logic          mem_rw_ex;
    logic [1:0]    mem_size_ex;
    logic          mem_se_ex;
    logic          load_sel_ex;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [7:0]    dbg_data;
    logic          rf_le_mem;
    logic [4:0]    mem_rd;
    logic [31:0]   MEM_MUX_OUT;
    logic          mem_misalign;

    modport master (
        output flush, rf_le_ex, ex_rd, alu_out, store_data,
               mem_en_ex, mem_rw_ex, mem_size_ex, mem_se_ex, load_sel_ex,
               dbg_we, dbg_addr, dbg_data,
        input  rf_le_mem, mem_rd, MEM_MUX_OUT, mem_misalign
    );

    modport slave (
        input  flush, rf_le_ex, ex_rd, alu_out, store_data,
               mem_en_ex, mem_rw_ex, mem_size_ex, mem_se_ex, load_sel_ex,
               dbg_we, dbg_addr, dbg_data,
        output rf_le_mem, mem_rd, MEM_MUX_OUT, mem_misalign
    );
endinterface

// File: rtl/mem_stage.sv
// SPARC MEM stage: EX/MEM pipeline register, big-endian byte-addressed data
// memory with combinational reads, and the ALU/load result select.
module mem_stage #(
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input logic        clk,
    input logic        R,
    mem_stage_if.slave bus
);
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_WALT = 2'b11
    } size_e;

    // EX/MEM register fields
    logic        rf_le_q;
    logic [4:0]  rd_q;
    logic [31:0] alu_q;
    logic [31:0] st_q;
    logic        en_q;
    logic        rw_q;
    size_e       size_q;
    logic        se_q;
    logic        ls_q;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] a0, a1, a2, a3;
    logic [7:0]    b0, b1, b2, b3;
    logic          misalign;
    logic          store_fire;
    logic [31:0]   load_data;

    always_ff @(posedge clk) begin
        if (R || bus.flush) begin
            rf_le_q <= 1'b0;
            rd_q    <= '0;
            alu_q   <= '0;
            st_q    <= '0;
            en_q    <= 1'b0;
            rw_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            se_q    <= 1'b0;
            ls_q    <= 1'b0;
        end else begin
            rf_le_q <= bus.rf_le_ex;
            rd_q    <= bus.ex_rd;
            alu_q   <= bus.alu_out;
            st_q    <= bus.store_data;
            en_q    <= bus.mem_en_ex;
            rw_q    <= bus.mem_rw_ex;
            size_q  <= size_e'(bus.mem_size_ex);
            se_q    <= bus.mem_se_ex;
            ls_q    <= bus.load_sel_ex;
        end
    end

    // Byte lane addresses wrap modulo DEPTH through AW-bit arithmetic.
    assign a0 = alu_q[AW-1:0];
    assign a1 = a0 + AW'(1);
    assign a2 = a0 + AW'(2);
    assign a3 = a0 + AW'(3);

    assign b0 = mem[a0];
    assign b1 = mem[a1];
    assign b2 = mem[a2];
    assign b3 = mem[a3];

    always_comb begin
        misalign = 1'b0;
        case (size_q)
            SZ_BYTE: misalign = 1'b0;
            SZ_HALF: misalign = a0[0];
            default: misalign = |a0[1:0];
        endcase
        misalign = misalign & en_q;
    end

    // Reset at the write edge suppresses the store.
    assign store_fire = en_q && rw_q && !misalign && !R;

    // A pipeline store blocks any debug write in the same cycle, whatever its address.
    always_ff @(posedge clk) begin
        if (store_fire) begin
            case (size_q)
                SZ_BYTE: mem[a0] <= st_q[7:0];
                SZ_HALF: begin
                    mem[a0] <= st_q[15:8];
                    mem[a1] <= st_q[7:0];
                end
                default: begin
                    mem[a0] <= st_q[31:24];
                    mem[a1] <= st_q[23:16];
                    mem[a2] <= st_q[15:8];
                    mem[a3] <= st_q[7:0];
                end
            endcase
        end else if (bus.dbg_we) begin
            mem[bus.dbg_addr] <= bus.dbg_data;
        end
    end

    // Loads read regardless of rw so a store with load_sel shows pre-write data.
    always_comb begin
        load_data = '0;
        if (en_q && !misalign) begin
            case (size_q)
                SZ_BYTE: load_data = {{24{se_q & b0[7]}}, b0};
                SZ_HALF: load_data = {{16{se_q & b0[7]}}, b0, b1};
                default: load_data = {b0, b1, b2, b3};
            endcase
        end
    end

    assign bus.rf_le_mem    = rf_le_q;
    assign bus.mem_rd       = rd_q;
    assign bus.MEM_MUX_OUT  = ls_q ? load_data : alu_q;
    assign bus.mem_misalign = misalign;
endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: loads/stores, alignment,
// flush/reset behaviour and debug-write arbitration.
module tb_mem_stage;
    localparam int AW    = 9;
    localparam int DEPTH = 512;

    logic clk;
    logic R;
    int   total;
    int   bad;

    mem_stage_if #(.AW(AW)) bus ();

    mem_stage #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .R   (R),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle;
        bus.flush       = 1'b0;
        bus.rf_le_ex    = 1'b0;
        bus.ex_rd       = '0;
        bus.alu_out     = '0;
        bus.store_data  = '0;
        bus.mem_en_ex   = 1'b0;
        bus.mem_rw_ex   = 1'b0;
        bus.mem_size_ex = 2'b00;
        bus.mem_se_ex   = 1'b0;
        bus.load_sel_ex = 1'b0;
        bus.dbg_we      = 1'b0;
        bus.dbg_addr    = '0;
        bus.dbg_data    = '0;
    endtask

    task automatic store(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] data,
                         input logic ls);
        idle();
        bus.mem_en_ex   = 1'b1;
        bus.mem_rw_ex   = 1'b1;
        bus.mem_size_ex = sz;
        bus.alu_out     = addr;
        bus.store_data  = data;
        bus.load_sel_ex = ls;
    endtask

    task automatic load(input logic [1:0] sz, input logic se, input logic [31:0] addr);
        idle();
        bus.mem_en_ex   = 1'b1;
        bus.mem_size_ex = sz;
        bus.mem_se_ex   = se;
        bus.alu_out     = addr;
        bus.load_sel_ex = 1'b1;
    endtask

    task automatic dbg_wr(input logic [AW-1:0] addr, input logic [7:0] data);
        bus.dbg_we   = 1'b1;
        bus.dbg_addr = addr;
        bus.dbg_data = data;
        step();
        bus.dbg_we   = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle();
        R = 1'b1;
        step();
        // Preload under reset: pipeline holds no store, so debug writes land.
        dbg_wr(9'h016, 8'h00);
        dbg_wr(9'h017, 8'h00);
        dbg_wr(9'h020, 8'hAA);
        dbg_wr(9'h030, 8'h00);
        dbg_wr(9'h031, 8'h00);
        check("rst_rf_le", {31'b0, bus.rf_le_mem}, 32'h0);
        check("rst_rd", {27'b0, bus.mem_rd}, 32'h0);
        check("rst_mux", bus.MEM_MUX_OUT, 32'h0);
        check("rst_misalign", {31'b0, bus.mem_misalign}, 32'h0);
        R = 1'b0;

        // Word store then immediate word load of the same address.
        store(2'b10, 32'h10, 32'hDEADBEEF, 1'b0);
        step();
        check("st_word_alu", bus.MEM_MUX_OUT, 32'h00000010);
        check("st_word_mis", {31'b0, bus.mem_misalign}, 32'h0);
        load(2'b10, 1'b0, 32'h10);
        step();
        check("ld_word_fwd", bus.MEM_MUX_OUT, 32'hDEADBEEF);
        load(2'b00, 1'b0, 32'h10); step(); check("ld_ub_10", bus.MEM_MUX_OUT, 32'h000000DE);
        load(2'b00, 1'b0, 32'h11); step(); check("ld_ub_11", bus.MEM_MUX_OUT, 32'h000000AD);
        load(2'b00, 1'b0, 32'h12); step(); check("ld_ub_12", bus.MEM_MUX_OUT, 32'h000000BE);
        load(2'b00, 1'b1, 32'h13); step(); check("ld_sb_13", bus.MEM_MUX_OUT, 32'hFFFFFFEF);
        load(2'b01, 1'b1, 32'h12); step(); check("ld_sh_12", bus.MEM_MUX_OUT, 32'hFFFFBEEF);
        load(2'b01, 1'b0, 32'h12); step(); check("ld_uh_12", bus.MEM_MUX_OUT, 32'h0000BEEF);
        load(2'b00, 1'b1, 32'h11); step(); check("ld_sb_11", bus.MEM_MUX_OUT, 32'hFFFFFFAD);

        // Misaligned word store writes nothing.
        store(2'b10, 32'h12, 32'h11111111, 1'b0);
        step();
        check("st_mis_flag", {31'b0, bus.mem_misalign}, 32'h1);
        load(2'b10, 1'b0, 32'h10);
        step();
        check("ld_after_mis_flag", {31'b0, bus.mem_misalign}, 32'h0);
        check("ld_after_mis", bus.MEM_MUX_OUT, 32'hDEADBEEF);
        load(2'b01, 1'b0, 32'h11);
        step();
        check("ld_mis_half", bus.MEM_MUX_OUT, 32'h0);
        check("ld_mis_half_flag", {31'b0, bus.mem_misalign}, 32'h1);
        load(2'b11, 1'b0, 32'h10);
        step();
        check("ld_size11", bus.MEM_MUX_OUT, 32'hDEADBEEF);

        // Store with load_sel shows pre-write contents.
        store(2'b10, 32'h10, 32'h01020304, 1'b1);
        step();
        check("st_ls_prewrite", bus.MEM_MUX_OUT, 32'hDEADBEEF);
        load(2'b10, 1'b0, 32'h10); step(); check("ld_new_word", bus.MEM_MUX_OUT, 32'h01020304);
        load(2'b10, 1'b0, 32'hFFFFFE10); step(); check("ld_wrap", bus.MEM_MUX_OUT, 32'h01020304);

        // Half store touches only its two bytes.
        store(2'b01, 32'h14, 32'h1234ABCD, 1'b0);
        step();
        load(2'b10, 1'b0, 32'h14); step(); check("ld_half_store", bus.MEM_MUX_OUT, 32'hABCD0000);

        // Non-memory op, then the same op flushed.
        idle();
        bus.rf_le_ex = 1'b1;
        bus.ex_rd    = 5'd7;
        bus.alu_out  = 32'h1234;
        step();
        check("alu_rf_le", {31'b0, bus.rf_le_mem}, 32'h1);
        check("alu_rd", {27'b0, bus.mem_rd}, 32'd7);
        check("alu_mux", bus.MEM_MUX_OUT, 32'h1234);
        bus.flush = 1'b1;
        step();
        check("flush_rf_le", {31'b0, bus.rf_le_mem}, 32'h0);
        check("flush_rd", {27'b0, bus.mem_rd}, 32'h0);
        check("flush_mux", bus.MEM_MUX_OUT, 32'h0);

        // Byte store killed by reset at its write edge.
        store(2'b00, 32'h20, 32'h00000055, 1'b0);
        bus.rf_le_ex = 1'b1;
        bus.ex_rd    = 5'd3;
        step();
        check("st_r_rd", {27'b0, bus.mem_rd}, 32'd3);
        idle();
        R = 1'b1;
        step();
        R = 1'b0;
        check("r_rf_le", {31'b0, bus.rf_le_mem}, 32'h0);
        check("r_rd", {27'b0, bus.mem_rd}, 32'h0);
        check("r_mux", bus.MEM_MUX_OUT, 32'h0);
        check("r_misalign", {31'b0, bus.mem_misalign}, 32'h0);
        load(2'b00, 1'b0, 32'h20); step(); check("ld_r_kept", bus.MEM_MUX_OUT, 32'h000000AA);

        // Debug write colliding with a store to the same byte.
        store(2'b00, 32'h30, 32'h00000077, 1'b0);
        step();
        idle();
        dbg_wr(9'h030, 8'h11);
        load(2'b00, 1'b0, 32'h30); step(); check("dbg_same_addr", bus.MEM_MUX_OUT, 32'h00000077);

        // Debug write dropped while a store to another byte fires.
        store(2'b00, 32'h31, 32'h00000066, 1'b0);
        step();
        idle();
        dbg_wr(9'h030, 8'h99);
        load(2'b00, 1'b0, 32'h31); step(); check("dbg_store_31", bus.MEM_MUX_OUT, 32'h00000066);
        load(2'b00, 1'b0, 32'h30); step(); check("dbg_dropped_30", bus.MEM_MUX_OUT, 32'h00000077);

        // A debug write with the pipeline idle does land.
        idle();
        step();
        dbg_wr(9'h030, 8'h5A);
        load(2'b00, 1'b0, 32'h30); step(); check("dbg_idle_30", bus.MEM_MUX_OUT, 32'h0000005A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
